// File: rtl/vec_wb_serializer.sv
// Write-back serializer: takes one vector result over valid/ready and emits it
// as consecutive word writes (least-significant word first), plus an OR-summary of lane flags.
module vec_wb_serializer #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH_V-1:0]                  in_result,
    input  logic [(WIDTH_V/BITS_INDEX)*4-1:0]   in_flags,
    input  logic [ADDR_W-1:0]                   in_addr,
    output logic                                wr_en,
    input  logic                                wr_ready,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [WORD_W-1:0]                   wr_data,
    output logic [3:0]                          flags_summary,
    output logic                                busy,
    output logic                                done
);
    localparam int NUM_LANES = WIDTH_V / BITS_INDEX;
    localparam int NUM_BEATS = WIDTH_V / WORD_W;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    // Handshakes (both channels): a transfer happens on a rising edge where
    // valid and ready are both high; valid holds its payload stable until then.

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_n;
    logic [WIDTH_V-1:0]  buffer;
    logic [ADDR_W-1:0]   base;
    logic [BEAT_W-1:0]   beat;
    logic [3:0]          summary_n;
    logic                accept;
    logic                beat_fire;
    logic                last_beat;

    assign last_beat = (beat == LAST_BEAT);
    assign wr_en     = (state == SEND);
    assign busy      = (state == SEND);
    assign beat_fire = wr_en && wr_ready;
    // Accepting on the final-beat edge keeps back-to-back vectors bubble-free.
    assign in_ready  = !rst && ((state == IDLE) || (state == SEND && last_beat && wr_ready));
    assign accept    = in_valid && in_ready;
    assign wr_addr   = base + ADDR_W'(beat);

    always_comb begin
        wr_data = '0;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (beat == BEAT_W'(b)) wr_data = buffer[b*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        summary_n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int k = 0; k < 4; k++) begin
                summary_n[k] = summary_n[k] | in_flags[4*i+k];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = SEND;
            SEND: if (beat_fire && last_beat) state_n = accept ? SEND : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer        <= '0;
            base          <= '0;
            beat          <= '0;
            flags_summary <= '0;
            done          <= 1'b0;
        end else begin
            done <= beat_fire && last_beat;
            if (accept) begin
                buffer        <= in_result;
                base          <= in_addr;
                flags_summary <= summary_n;
                beat          <= '0;
            end else if (beat_fire) begin
                beat <= last_beat ? '0 : beat + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vec_wb_serializer.sv
// Directed bench for vec_wb_serializer: linear steps, expected values written by hand.
module tb_vec_wb_serializer;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_result;
    logic [63:0]  in_flags;
    logic [15:0]  in_addr;
    logic         wr_en;
    logic         wr_ready;
    logic [15:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   flags_summary;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    vec_wb_serializer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_addr(in_addr),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .flags_summary(flags_summary), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] addr, input logic [31:0] data);
        chk({tag, "_wr_en"}, wr_en, 1'b1);
        chk({tag, "_addr"}, wr_addr, addr);
        chk({tag, "_data"}, wr_data, data);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_wr_addr"}, wr_addr, 16'h0);
        chk({tag, "_wr_data"}, wr_data, 32'h0);
        chk({tag, "_flags"}, flags_summary, 4'h0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic send(input logic [127:0] res, input logic [63:0] flg, input logic [15:0] addr);
        in_valid  = 1'b1;
        in_result = res;
        in_flags  = flg;
        in_addr   = addr;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_addr = '0; wr_ready = 1'b1;
        #1;
        chk_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);

        // Uniform data
        send({16{8'h1E}}, 64'h0, 16'h0010);
        chk("u_busy", busy, 1'b1);
        chk("u_in_ready_b0", in_ready, 1'b0);
        chk_beat("u_b0", 16'h0010, 32'h1E1E1E1E); tick();
        chk_beat("u_b1", 16'h0011, 32'h1E1E1E1E); tick();
        chk_beat("u_b2", 16'h0012, 32'h1E1E1E1E);
        chk("u_done_early", done, 1'b0); tick();
        chk_beat("u_b3", 16'h0013, 32'h1E1E1E1E);
        chk("u_in_ready_b3", in_ready, 1'b1); tick();
        chk("u_done", done, 1'b1);
        chk("u_wr_en_off", wr_en, 1'b0);
        chk("u_busy_off", busy, 1'b0); tick();
        chk("u_done_off", done, 1'b0);

        // Lane ordering
        send(128'h0F0E0D0C_0B0A0908_07060504_03020100, 64'h0, 16'h0000);
        chk_beat("lo_b0", 16'h0000, 32'h03020100); tick();
        chk_beat("lo_b1", 16'h0001, 32'h07060504); tick();
        chk_beat("lo_b2", 16'h0002, 32'h0B0A0908); tick();
        chk_beat("lo_b3", 16'h0003, 32'h0F0E0D0C); tick();
        chk("lo_done", done, 1'b1); tick();

        // Backpressure for 3 cycles on beat 1; in_valid offered but must be ignored
        send(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 64'h0, 16'h0020);
        chk_beat("bp_b0", 16'h0020, 32'hAAAAAAAA); tick();
        wr_ready = 1'b0;
        in_valid = 1'b1; in_result = {16{8'h77}}; in_addr = 16'h0999;
        for (int s = 0; s < 3; s++) begin
            chk_beat("bp_stall", 16'h0021, 32'hBBBBBBBB);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_done", done, 1'b0);
            tick();
        end
        wr_ready = 1'b1;
        in_valid = 1'b0;
        chk_beat("bp_b1", 16'h0021, 32'hBBBBBBBB); tick();
        chk_beat("bp_b2", 16'h0022, 32'hCCCCCCCC); tick();
        chk_beat("bp_b3", 16'h0023, 32'hDDDDDDDD); tick();
        chk("bp_done_end", done, 1'b1);
        chk("bp_busy_end", busy, 1'b0); tick();

        // Back-to-back vectors
        send(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 64'h0, 16'h0100);
        in_valid = 1'b1; in_result = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0; in_addr = 16'h0104;
        chk_beat("bb_a0", 16'h0100, 32'hA0A0A0A0);
        chk("bb_a0_ready", in_ready, 1'b0); tick();
        chk_beat("bb_a1", 16'h0101, 32'hA1A1A1A1); tick();
        chk_beat("bb_a2", 16'h0102, 32'hA2A2A2A2); tick();
        chk_beat("bb_a3", 16'h0103, 32'hA3A3A3A3);
        chk("bb_a3_ready", in_ready, 1'b1); tick();
        in_valid = 1'b0;
        chk("bb_done_a", done, 1'b1);
        chk_beat("bb_b0", 16'h0104, 32'hB0B0B0B0); tick();
        chk("bb_done_a_off", done, 1'b0);
        chk_beat("bb_b1", 16'h0105, 32'hB1B1B1B1); tick();
        chk_beat("bb_b2", 16'h0106, 32'hB2B2B2B2); tick();
        chk_beat("bb_b3", 16'h0107, 32'hB3B3B3B3); tick();
        chk("bb_done_b", done, 1'b1);
        chk("bb_idle", wr_en, 1'b0); tick();

        // Address wrap and flag summary (lane 3 = 0001, lane 15 = 1000)
        send(128'h44444444_33333333_22222222_11111111, 64'h8000_0000_0000_1000, 16'hFFFE);
        chk("wf_flags", flags_summary, 4'b1001);
        chk_beat("wf_b0", 16'hFFFE, 32'h11111111); tick();
        chk_beat("wf_b1", 16'hFFFF, 32'h22222222); tick();
        chk_beat("wf_b2", 16'h0000, 32'h33333333); tick();
        chk_beat("wf_b3", 16'h0001, 32'h44444444); tick();
        chk("wf_done", done, 1'b1); tick();
        chk("wf_flags_hold", flags_summary, 4'b1001);

        // Asynchronous reset during beat 2
        send(128'h5555_5555_6666_6666_7777_7777_8888_8888, 64'h0000_0000_0000_0004, 16'h0040);
        chk("rs_flags", flags_summary, 4'b0100);
        chk_beat("rs_b0", 16'h0040, 32'h88888888); tick();
        chk_beat("rs_b1", 16'h0041, 32'h77777777); tick();
        chk_beat("rs_b2", 16'h0042, 32'h66666666);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rs_async");
        tick();
        chk("rs_no_done", done, 1'b0);
        rst = 1'b0;
        #1;
        chk("rs_ready_after", in_ready, 1'b1);
        chk("rs_idle_after", busy, 1'b0);
        send(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 64'h0, 16'h0050);
        chk_beat("rs2_b0", 16'h0050, 32'h0A0A0A0A); tick();
        chk_beat("rs2_b1", 16'h0051, 32'h0B0B0B0B); tick();
        chk_beat("rs2_b2", 16'h0052, 32'h0C0C0C0C); tick();
        chk_beat("rs2_b3", 16'h0053, 32'h0D0D0D0D); tick();
        chk("rs2_done", done, 1'b1); tick();
        chk("rs2_done_off", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
